// File: rtl/add_reservation_station.sv
// Single-entry reservation station with an adder/subtractor FU, issue on negedge, result on posedge.
// Optional RS_TRACE_EN macro enables simulation trace messages; behaviour is identical without it.
//
// state    | meaning
// S_IDLE   | not executing: empty (busy=0) or WAIT_OPS (busy=1, operand tag pending)
// S_EXEC   | operands ready, latency counter running
// S_RESULT | result and valid driven on own ROB slot for one full clock
module add_reservation_station #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 15,
  parameter int RB_INDEX  = 4,
  parameter int FU_INDEX  = 4,
  parameter int REG_INDEX = 4,
  parameter logic [FU_INDEX-1:0] FU_ID = '0,
  parameter int LATENCY   = 2,
  parameter logic [RB_INDEX-1:0] READY = 4'hF,
  parameter logic [3:0] OP_ADD  = 4'h0,
  parameter logic [3:0] OP_SUB  = 4'h1,
  parameter logic [3:0] OP_ADDI = 4'h2,
  parameter logic [3:0] OP_SUBI = 4'h3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [FU_INDEX-1:0]           CDB_inst_fu,
  input  logic [WORD_SIZE-1:0]          CDB_inst_inst,
  input  logic [RB_INDEX-1:0]           CDB_inst_RBindex,
  output logic [REG_INDEX-1:0]          numj,
  output logic [REG_INDEX-1:0]          numk,
  input  logic [WORD_SIZE-1:0]          vj,
  input  logic [WORD_SIZE-1:0]          vk,
  input  logic [RB_INDEX-1:0]           qj,
  input  logic [RB_INDEX-1:0]           qk,
  input  logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_data,
  input  logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic [RB_SIZE*WORD_SIZE-1:0]  data_out,
  output logic [RB_SIZE-1:0]            valid_out,
  output logic                          busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESULT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_issue_tog, r_free_tog, r_sub;
  logic [RB_INDEX-1:0]    r_rbindex, r_qj, r_qk, w_qj_nxt, w_qk_nxt;
  logic [WORD_SIZE-1:0]   r_vj, r_vk, w_vj_nxt, w_vk_nxt;
  logic                   w_busy, w_issue, w_ops_ready, w_imm_op, w_sub_op, w_known_op;
  logic [3:0]             w_opcode;
  logic [WORD_SIZE-1:0]   w_imm_ext, w_result;
  logic                   w_unused;

  function automatic logic f_hit(input logic [RB_INDEX-1:0] tag, input logic [RB_SIZE-1:0] vld);
    f_hit = 1'b0;
    for (int i = 0; i < RB_SIZE; i++)
      if (tag == RB_INDEX'(i) && vld[i]) f_hit = 1'b1;
  endfunction

  function automatic logic [WORD_SIZE-1:0] f_slot(input logic [RB_INDEX-1:0] tag,
                                                  input logic [RB_SIZE*WORD_SIZE-1:0] dat);
    f_slot = '0;
    for (int i = 0; i < RB_SIZE; i++)
      if (tag == RB_INDEX'(i)) f_slot = dat[i*WORD_SIZE +: WORD_SIZE];
  endfunction

  assign numj      = CDB_inst_inst[20 +: REG_INDEX];
  assign numk      = CDB_inst_inst[16 +: REG_INDEX];
  assign w_unused  = ^CDB_inst_inst[27:24];
  assign w_opcode  = CDB_inst_inst[31:28];
  assign w_imm_op  = (w_opcode == OP_ADDI) || (w_opcode == OP_SUBI);
  assign w_sub_op  = (w_opcode == OP_SUB)  || (w_opcode == OP_SUBI);
  assign w_known_op = w_imm_op || w_sub_op || (w_opcode == OP_ADD);
  assign w_imm_ext = {{(WORD_SIZE-16){CDB_inst_inst[15]}}, CDB_inst_inst[15:0]};

  // busy rises on the issue negedge and falls on the posedge closing RESULT
  assign w_busy      = r_issue_tog ^ r_free_tog;
  assign w_issue     = !w_busy && (CDB_inst_fu == FU_ID);
  assign w_ops_ready = (r_qj == READY) && (r_qk == READY);
  assign w_result    = r_sub ? (r_vj - r_vk) : (r_vj + r_vk);

  // Operand resolution: issue load, then same-edge CDB snoop (covers bypass and WAIT_OPS)
  always_comb begin
    w_qj_nxt = r_qj;
    w_vj_nxt = r_vj;
    w_qk_nxt = r_qk;
    w_vk_nxt = r_vk;
    if (w_issue) begin
      w_qj_nxt = qj;
      w_vj_nxt = vj;
      w_qk_nxt = w_imm_op ? READY : qk;
      w_vk_nxt = w_imm_op ? w_imm_ext : vk;
    end
    if (w_qj_nxt != READY && f_hit(w_qj_nxt, CDB_data_valid)) begin
      w_vj_nxt = f_slot(w_qj_nxt, CDB_data_data);
      w_qj_nxt = READY;
    end
    if (w_qk_nxt != READY && f_hit(w_qk_nxt, CDB_data_valid)) begin
      w_vk_nxt = f_slot(w_qk_nxt, CDB_data_data);
      w_qk_nxt = READY;
    end
  end

  always_ff @(negedge clk or posedge reset or posedge flush) begin
    if (reset || flush) begin
      r_issue_tog <= 1'b0;
      r_sub       <= 1'b0;
      r_rbindex   <= '0;
      r_qj        <= READY;
      r_qk        <= READY;
      r_vj        <= '0;
      r_vk        <= '0;
    end else begin
      r_qj <= w_qj_nxt;
      r_qk <= w_qk_nxt;
      r_vj <= w_vj_nxt;
      r_vk <= w_vk_nxt;
      if (w_issue) begin
        r_issue_tog <= ~r_issue_tog;
        r_sub       <= w_sub_op;
        r_rbindex   <= CDB_inst_RBindex;
      end
    end
  end

  always_ff @(posedge clk or posedge reset or posedge flush) begin
    if (reset || flush) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_free_tog <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_RESULT) r_free_tog <= ~r_free_tog;
    end
  end

  // The first posedge after operands resolve is already the first latency tick
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_busy && w_ops_ready) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESULT;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_EXEC;
            w_cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_EXEC: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_RESULT;
      end
      S_RESULT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = w_busy;
    valid_out = '0;
    data_out  = '0;
    if (r_state == S_RESULT) begin
      for (int i = 0; i < RB_SIZE; i++) begin
        if (r_rbindex == RB_INDEX'(i)) begin
          valid_out[i]                     = 1'b1;
          data_out[i*WORD_SIZE +: WORD_SIZE] = w_result;
        end
      end
    end
  end

`ifdef RS_TRACE_EN
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (w_issue) begin
        $display("%t add_rs[%0d]: issue rb=%0d inst=%h", $realtime, FU_ID, CDB_inst_RBindex, CDB_inst_inst);
        if (!w_known_op)
          $display("%t add_rs[%0d]: fatal: undefined opcode %h executed as ADD", $realtime, FU_ID, w_opcode);
      end
      if ((w_issue ? (qj != READY) : (r_qj != READY)) && w_qj_nxt == READY)
        $display("%t add_rs[%0d]: capture j tag=%0d value=%h", $realtime, FU_ID, w_issue ? qj : r_qj, w_vj_nxt);
      if ((w_issue ? (qk != READY && !w_imm_op) : (r_qk != READY)) && w_qk_nxt == READY)
        $display("%t add_rs[%0d]: capture k tag=%0d value=%h", $realtime, FU_ID, w_issue ? qk : r_qk, w_vk_nxt);
    end
  end
  always @(posedge clk) begin
    if (!reset && !flush && r_state != S_RESULT && w_state_nxt == S_RESULT)
      $display("%t add_rs[%0d]: result rb=%0d value=%h", $realtime, FU_ID, r_rbindex, w_result);
  end
  always @(posedge flush) begin
    $display("%t add_rs[%0d]: flush", $realtime, FU_ID);
  end
`else
`endif

endmodule

// File: tb/tb_add_reservation_station.sv
// Randomized scoreboard bench for add_reservation_station: stimulus pushes expected results,
// a negedge monitor pops and compares whenever valid_out is raised.
module tb_add_reservation_station;
  localparam int WS  = 32;
  localparam int RBS = 15;
  localparam int LAT = 2;
  localparam logic [3:0] RDY  = 4'hF;
  localparam logic [3:0] FUID = 4'd0;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_ADDI = 4'h2, OP_SUBI = 4'h3;

  logic              clk = 1'b0;
  logic              reset, flush;
  logic [3:0]        CDB_inst_fu;
  logic [WS-1:0]     CDB_inst_inst;
  logic [3:0]        CDB_inst_RBindex;
  logic [3:0]        numj, numk;
  logic [WS-1:0]     vj, vk;
  logic [3:0]        qj, qk;
  logic [RBS*WS-1:0] CDB_data_data;
  logic [RBS-1:0]    CDB_data_valid;
  logic [RBS*WS-1:0] data_out;
  logic [RBS-1:0]    valid_out;
  logic              busy;

  add_reservation_station #(.FU_ID(FUID), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .CDB_inst_fu(CDB_inst_fu), .CDB_inst_inst(CDB_inst_inst), .CDB_inst_RBindex(CDB_inst_RBindex),
    .numj(numj), .numk(numk), .vj(vj), .vk(vk), .qj(qj), .qk(qk),
    .CDB_data_data(CDB_data_data), .CDB_data_valid(CDB_data_valid),
    .data_out(data_out), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; int rb; logic [WS-1:0] val; } exp_t;
  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: the ROB samples results at the negedge inside the result cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_out != '0) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_result: valid_out=%b data_out=%h cycle %0d", valid_out, data_out, cyc);
        end else begin
          exp_t e;
          logic [RBS-1:0]    ev;
          logic [RBS*WS-1:0] ed;
          e  = sbq.pop_front();
          ev = '0;
          ev[e.rb] = 1'b1;
          ed = '0;
          ed[e.rb*WS +: WS] = e.val;
          if (valid_out !== ev || data_out !== ed || cyc != e.at) begin
            n_fail++;
            $display("FAIL result: got valid=%b slot=%h cycle %0d expected valid=%b slot=%h cycle %0d",
                     valid_out, data_out[e.rb*WS +: WS], cyc, ev, e.val, e.at);
          end
        end
      end else begin
        n_tests++;
        if (data_out != '0) begin
          n_fail++;
          $display("FAIL data_without_valid: data_out=%h expected 0 cycle %0d", data_out, cyc);
        end
      end
    end
  end

  task automatic txn(input logic [3:0] fu, input logic [3:0] opc, input int rb,
                     input logic [3:0] tj, input logic [WS-1:0] aj, input int dj,
                     input logic [3:0] tk, input logic [WS-1:0] ak, input int dk,
                     input logic [15:0] imm, input int flush_off);
    logic imm_op, sub_op, j_pend, k_pend;
    logic [WS-1:0] bval, res;
    logic [3:0] rs, rt;
    logic [RBS-1:0] excl;
    int c, r, dmax;
    imm_op = (opc == OP_ADDI) || (opc == OP_SUBI);
    sub_op = (opc == OP_SUB)  || (opc == OP_SUBI);
    j_pend = (tj != RDY);
    k_pend = !imm_op && (tk != RDY);
    bval   = imm_op ? {{16{imm[15]}}, imm} : ak;
    res    = sub_op ? aj - bval : aj + bval;
    dmax   = 0;
    if (j_pend) dmax = dj;
    if (k_pend && dk > dmax) dmax = dk;
    excl = '0;
    if (j_pend) excl[tj] = 1'b1;
    if (k_pend) excl[tk] = 1'b1;
    c = 0;
    r = 0;
    for (int d = 0; d < 64; d++) begin
      @(posedge clk); #1;
      for (int s = 0; s < RBS; s++) CDB_data_data[s*WS +: WS] = $urandom;
      CDB_data_valid = RBS'($urandom) & ~excl;
      if (j_pend && d == dj) begin
        CDB_data_valid[tj] = 1'b1;
        CDB_data_data[tj*WS +: WS] = aj;
      end
      if (k_pend && d == dk) begin
        CDB_data_valid[tk] = 1'b1;
        CDB_data_data[tk*WS +: WS] = ak;
      end
      CDB_inst_fu = FUID + 4'd1;
      if (d == 0) begin
        c  = cyc;
        r  = c + dmax;
        rs = 4'($urandom);
        rt = 4'($urandom);
        CDB_inst_fu      = fu;
        CDB_inst_inst    = {opc, 4'($urandom), rs, rt, imm};
        CDB_inst_RBindex = 4'(rb);
        qj = tj;
        qk = tk;
        vj = j_pend ? $urandom : aj;
        vk = (k_pend || imm_op) ? $urandom : ak;
        #1;
        chk("numj", 32'(numj), 32'(rs));
        chk("numk", 32'(numk), 32'(rt));
        if (fu == FUID && flush_off < 0) sbq.push_back('{r + LAT, rb, res});
        @(negedge clk); #1;
        chk("busy_at_issue", 32'(busy), 32'(fu == FUID));
      end else if (fu != FUID) begin
        chk("busy_ignored_issue", 32'(busy), 32'd0);
        break;
      end else begin
        if (flush_off >= 0 && cyc == r + flush_off) begin
          flush = 1'b1;
          #1;
          chk("flush_busy", 32'(busy), 32'd0);
          chk("flush_valid", 32'(valid_out), 32'd0);
          chk("flush_data", 32'(|data_out), 32'd0);
          #2 flush = 1'b0;
        end else if (d == 1) begin
          CDB_inst_fu      = FUID;
          CDB_inst_inst    = $urandom;
          CDB_inst_RBindex = 4'($urandom_range(0, RBS-1));
          qj = RDY;
          qk = RDY;
          vj = $urandom;
          vk = $urandom;
        end
        if (cyc == r + LAT + 1) begin
          chk("busy_after_result", 32'(busy), 32'd0);
          break;
        end
      end
    end
    CDB_inst_fu    = FUID + 4'd1;
    CDB_data_valid = '0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    CDB_inst_fu = FUID + 4'd1;
    CDB_inst_inst = '0;
    CDB_inst_RBindex = '0;
    vj = '0; vk = '0; qj = RDY; qk = RDY;
    CDB_data_data = '0;
    CDB_data_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_data", 32'(|data_out), 32'd0);
    reset = 1'b0;

    txn(FUID, OP_ADD, 3, RDY, 32'd5, 0, RDY, 32'd7, 0, 16'd0, -1);
    txn(FUID, OP_SUBI, 5, 4'd4, 32'd10, 2, RDY, 32'd0, 0, 16'd3, -1);
    txn(FUID, OP_ADD, 0, RDY, 32'hFFFFFFFF, 0, RDY, 32'd1, 0, 16'd0, -1);
    txn(FUID, OP_SUB, 14, RDY, 32'd0, 0, RDY, 32'd1, 0, 16'd0, -1);
    txn(FUID, OP_ADD, 8, 4'd6, 32'd9, 0, RDY, 32'd1, 0, 16'd0, -1);
    txn(FUID, OP_ADD, 7, RDY, 32'd100, 0, RDY, 32'd23, 0, 16'd0, 1);
    txn(FUID, OP_ADD, 1, RDY, 32'd40, 0, RDY, 32'd2, 0, 16'd0, -1);
    txn(FUID + 4'd1, OP_ADD, 2, RDY, 32'd1, 0, RDY, 32'd1, 0, 16'd0, -1);
    txn(FUID, OP_SUB, 2, 4'd9, 32'd50, 1, 4'd9, 32'd50, 1, 16'd0, -1);
    txn(FUID, OP_SUB, 4, 4'd2, 32'd300, 3, 4'd11, 32'd45, 1, 16'd0, -1);
    txn(FUID, OP_ADDI, 6, RDY, 32'd10, 0, 4'd3, 32'd0, 0, 16'hFFFE, -1);
    txn(FUID, 4'hA, 9, RDY, 32'd20, 0, RDY, 32'd22, 0, 16'd0, -1);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] fu, opc, tj, tk;
      logic [WS-1:0] aj, ak;
      int dj, dk, fl;
      fu  = ($urandom_range(0, 9) == 0) ? FUID + 4'd1 : FUID;
      opc = 4'($urandom_range(0, 5));
      tj  = ($urandom_range(0, 1) == 0) ? RDY : 4'($urandom_range(0, RBS-1));
      tk  = ($urandom_range(0, 1) == 0) ? RDY : 4'($urandom_range(0, RBS-1));
      dj  = $urandom_range(0, 3);
      dk  = $urandom_range(0, 3);
      aj  = $urandom;
      ak  = $urandom;
      if (tj != RDY && $urandom_range(0, 3) == 0) tk = tj;
      if (tj != RDY && tk == tj) begin
        dk = dj;
        ak = aj;
      end
      fl = ($urandom_range(0, 6) == 0) ? $urandom_range(1, LAT - 1) : -1;
      txn(fu, opc, $urandom_range(0, RBS-1), tj, aj, dj, tk, ak, dk, 16'($urandom), fl);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("leftover_results", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
